// File: rtl/seg7_bank.sv
// Bank of NUM_DIGITS active-low 7-segment digit registers with per-digit blink mask.
// Digits take either raw segments or a hex-decoded nibble; address 7 is the blink control register.
module seg7_bank #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic [7:0]              Data,
    input  logic [2:0]              Addr,
    input  logic                    Sel,
    output logic [7*NUM_DIGITS-1:0] H,
    output logic                    Ack,
    output logic                    Err
);

    localparam int            CW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
    localparam logic [3:0]    NUMD    = 4'(NUM_DIGITS);

    typedef enum logic {
        VISIBLE = 1'b0,
        BLANK   = 1'b1
    } phase_t;

    logic [6:0]            digit_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] bm_q;
    logic [CW-1:0]         cnt_q;
    phase_t                phase_q;

    logic       ctrl_wr;
    logic       digit_wr;
    logic       bad_wr;
    logic [6:0] wr_pattern;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Address 7 always means control, even when NUM_DIGITS reaches 8.
    always_comb begin
        ctrl_wr    = Sel && (Addr == 3'd7);
        digit_wr   = Sel && !ctrl_wr && ({1'b0, Addr} < NUMD);
        bad_wr     = Sel && !ctrl_wr && !digit_wr;
        wr_pattern = Data[7] ? hex7(Data[3:0]) : Data[6:0];
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                digit_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (digit_wr && ({1'b0, Addr} == 4'(k))) begin
                    digit_q[k] <= wr_pattern;
                end
            end
        end
    end

    // A control write restarts the blink cycle, overriding a simultaneous wrap.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            bm_q    <= '0;
            cnt_q   <= '0;
            phase_q <= VISIBLE;
        end else if (ctrl_wr) begin
            bm_q    <= Data[NUM_DIGITS-1:0];
            cnt_q   <= '0;
            phase_q <= VISIBLE;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            phase_q <= (phase_q == VISIBLE) ? BLANK : VISIBLE;
        end else begin
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Ack <= 1'b0;
            Err <= 1'b0;
        end else begin
            Ack <= digit_wr || ctrl_wr;
            Err <= bad_wr;
        end
    end

    always_comb begin
        H = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!(bm_q[k] && (phase_q == BLANK))) begin
                H[7*k +: 7] = ~digit_q[k];
            end
        end
    end

endmodule
